pulse_sequencer: RTL

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

---
 rtl/pulse_seq_pkg.sv | 30 +++
 rtl/pulse_ramp.sv | 44 ++++
 rtl/pulse_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_seq_pkg.sv
// ============================================================================
// pulse_seq_pkg : shared types and constants for the pulse sequencer
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_seq_pkg;

   localparam int DEF_AW = 12;
   localparam int DEF_TW = 16;

   localparam logic [2:0] PH_IDLE  = 3'd0;
   localparam logic [2:0] PH_DELAY = 3'd1;
   localparam logic [2:0] PH_RISE  = 3'd2;
   localparam logic [2:0] PH_HIGH  = 3'd3;
   localparam logic [2:0] PH_FALL  = 3'd4;
   localparam logic [2:0] PH_LOW   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = PH_IDLE,
      S_DELAY = PH_DELAY,
      S_RISE  = PH_RISE,
      S_HIGH  = PH_HIGH,
      S_FALL  = PH_FALL,
      S_LOW   = PH_LOW
   } state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_ramp.sv
// ============================================================================
// pulse_ramp : one saturating ramp step toward a limit (up or down)
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_ramp
   import pulse_seq_pkg::*;
#(
   parameter int AW = DEF_AW
) (
   input  logic          i_down,
   input  logic [AW-1:0] i_level,
   input  logic [AW-1:0] i_step,
   input  logic [AW-1:0] i_limit,
   output logic [AW-1:0] o_next,
   output logic          o_at_limit
);

   logic [AW:0]   w_sum;
   logic [AW:0]   w_dif;
   logic [AW-1:0] w_next;

   // One extra bit so that overflow and underflow are visible before clamping
   assign w_sum = {1'b0, i_level} + {1'b0, i_step};
   assign w_dif = {1'b0, i_level} - {1'b0, i_step};

   always_comb begin
      w_next = i_limit;
      if (i_step == '0) begin
         w_next = i_limit;
      end else if (!i_down) begin
         if (w_sum < {1'b0, i_limit}) w_next = w_sum[AW-1:0];
      end else begin
         if (!w_dif[AW] && (w_dif > {1'b0, i_limit})) w_next = w_dif[AW-1:0];
      end
   end

   assign o_next     = w_next;
   assign o_at_limit = (w_next == i_limit);

endmodule

`default_nettype wire

// File: rtl/pulse_sequencer.sv
// ============================================================================
// pulse_sequencer : trapezoidal pulse-train generator (delay/rise/high/fall/low)
// Option macro    : PULSE_SEQ_EXT_TRIG_EN adds input trig gating the LOW exit
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_sequencer
   import pulse_seq_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int TW = DEF_TW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic [TW-1:0] td,
   input  logic [TW-1:0] th,
   input  logic [TW-1:0] tl,
   input  logic [AW-1:0] iv,
   input  logic [AW-1:0] pv,
   input  logic [AW-1:0] rise_step,
   input  logic [AW-1:0] fall_step,
   input  logic [TW-1:0] n_pulses,
`ifdef PULSE_SEQ_EXT_TRIG_EN
   input  logic          trig,
`endif
   output logic [AW-1:0] level,
   output logic [2:0]    phase,
   output logic          busy,
   output logic          done,
   output logic          cfg_err
);

   state_t        r_state;
   logic [AW-1:0] r_level;
   logic [AW-1:0] r_iv;
   logic [AW-1:0] r_pv;
   logic [AW-1:0] r_rs;
   logic [AW-1:0] r_fs;
   logic [TW-1:0] r_th;
   logic [TW-1:0] r_tl;
   logic [TW-1:0] r_n;
   logic [TW-1:0] r_tmr;
   logic [TW-1:0] r_cnt;
   logic          r_stop;
   logic          r_done;
   logic          r_cfg_err;
`ifdef PULSE_SEQ_EXT_TRIG_EN
   logic          r_wait;
`endif

   logic          w_down;
   logic [AW-1:0] w_step;
   logic [AW-1:0] w_limit;
   logic [AW-1:0] w_next;
   logic          w_at_lim;
   logic          w_last;
   logic          w_stop_any;

   assign w_down     = (r_state == S_FALL);
   assign w_step     = w_down ? r_fs : r_rs;
   assign w_limit    = w_down ? r_iv : r_pv;
   assign w_last     = (r_n != '0) && ((r_cnt + TW'(1)) == r_n);
   assign w_stop_any = stop | r_stop;

   pulse_ramp #(.AW(AW)) u_ramp (
      .i_down     (w_down),
      .i_level    (r_level),
      .i_step     (w_step),
      .i_limit    (w_limit),
      .o_next     (w_next),
      .o_at_limit (w_at_lim)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_level   <= '0;
         r_iv      <= '0;
         r_pv      <= '0;
         r_rs      <= '0;
         r_fs      <= '0;
         r_th      <= '0;
         r_tl      <= '0;
         r_n       <= '0;
         r_tmr     <= '0;
         r_cnt     <= '0;
         r_stop    <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
`ifdef PULSE_SEQ_EXT_TRIG_EN
         r_wait    <= 1'b0;
`endif
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         // Later assignments in the run-end branches clear this again
         if (stop && (r_state != S_IDLE)) r_stop <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (pv < iv) begin
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_iv    <= iv;
                     r_pv    <= pv;
                     r_rs    <= rise_step;
                     r_fs    <= fall_step;
                     r_th    <= th;
                     r_tl    <= tl;
                     r_n     <= n_pulses;
                     r_level <= iv;
                     r_cnt   <= '0;
                     r_stop  <= stop;
                     if (td != '0) begin
                        r_state <= S_DELAY;
                        r_tmr   <= td;
                     end else begin
                        r_state <= S_RISE;
                     end
                  end
               end
            end

            S_DELAY: begin
               if (stop) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                  r_stop  <= 1'b0;
                  r_level <= r_iv;
               end else if (r_tmr == TW'(1)) begin
                  r_state <= S_RISE;
               end else begin
                  r_tmr <= r_tmr - TW'(1);
               end
            end

            S_RISE: begin
               r_level <= w_next;
               if (w_at_lim) begin
                  if (r_th != '0) begin
                     r_state <= S_HIGH;
                     r_tmr   <= r_th;
                  end else begin
                     r_state <= S_FALL;
                  end
               end
            end

            S_HIGH: begin
               if (r_tmr == TW'(1)) r_state <= S_FALL;
               else                 r_tmr   <= r_tmr - TW'(1);
            end

            S_FALL: begin
               r_level <= w_next;
               if (w_at_lim) begin
                  r_cnt <= r_cnt + TW'(1);
                  if (w_last || w_stop_any) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                     r_stop  <= 1'b0;
                  end else begin
`ifdef PULSE_SEQ_EXT_TRIG_EN
                     r_state <= S_LOW;
                     r_tmr   <= r_tl;
                     r_wait  <= (r_tl == '0);
`else
                     if (r_tl != '0) begin
                        r_state <= S_LOW;
                        r_tmr   <= r_tl;
                     end else begin
                        r_state <= S_RISE;
                     end
`endif
                  end
               end
            end

            S_LOW: begin
`ifdef PULSE_SEQ_EXT_TRIG_EN
               // trig only counts once the low time has fully elapsed
               if (!r_wait) begin
                  if (r_tmr == TW'(1)) r_wait <= 1'b1;
                  else                 r_tmr  <= r_tmr - TW'(1);
               end else if (w_stop_any) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                  r_stop  <= 1'b0;
               end else if (trig) begin
                  r_state <= S_RISE;
               end
`else
               if (r_tmr == TW'(1)) r_state <= S_RISE;
               else                 r_tmr   <= r_tmr - TW'(1);
`endif
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign level   = r_level;
   assign phase   = r_state;
   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;
   assign cfg_err = r_cfg_err;

endmodule

`default_nettype wire
